// File: rtl/knn_pkg.sv
// Shared types and constants for the k-NN query path: FSM states, vote size
// and the distance width used by the selector and the distance units.
package knn_pkg;
   typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, DRAIN, SETTLE, RESULT} state_t;

   localparam int K          = 5;
   localparam int MAJ_THRESH = 3;

   localparam int              DIST_W   = 19;
   localparam logic [DIST_W-1:0] DIST_MAX = 19'h7FFFF;
endpackage

// File: rtl/knn_vote.sv
// Majority vote over the K nearest classes: popcount plus threshold compare.
// Purely combinational.
module knn_vote
   import knn_pkg::*;
(
   input  logic [K-1:0] cls_i,
   output logic [2:0]   votes_o,
   output logic         maj_o
);
   logic [2:0] cnt;

   always_comb begin
      cnt = '0;
      for (int i = 0; i < K; i++) begin
         cnt = cnt + {2'b00, cls_i[i]};
      end
   end

   assign votes_o = cnt;
   assign maj_o   = (cnt >= 3'(MAJ_THRESH));
endmodule

// File: rtl/knn_query_ctrl.sv
// Sequences one k-NN query: clear selector, stream sample pairs, align the
// selector strobe to the datapath latency, vote, then hand off the result.
module knn_query_ctrl
   import knn_pkg::*;
#(
   parameter int N_TRAIN  = 256,
   parameter int ADDR_W   = $clog2(N_TRAIN),
   parameter int PIPE_LAT = 3,
   parameter int SEL_LAT  = 1,
   parameter int QCNT_W   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              mem_en,
   output logic [ADDR_W-1:0] addr_a,
   output logic [ADDR_W-1:0] addr_b,
   output logic              sel_clr,
   output logic              sel_valid,
   input  logic [4:0]        cls_in,
   output logic              result_valid,
   input  logic              result_ready,
   output logic              result_class,
   output logic [2:0]        result_votes,
   output logic [QCNT_W-1:0] query_cnt
);
   localparam int CNT_MAX = (PIPE_LAT > SEL_LAT) ? PIPE_LAT : SEL_LAT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(N_TRAIN - 2);

   if (N_TRAIN < 2 || (N_TRAIN % 2) != 0) begin : g_bad_ntrain
      $error("knn_query_ctrl: N_TRAIN must be even and at least 2");
   end
   if (PIPE_LAT < 1 || SEL_LAT < 1) begin : g_bad_lat
      $error("knn_query_ctrl: PIPE_LAT and SEL_LAT must be at least 1");
   end

   state_t              state_q;
   logic                busy_q, mem_en_q, sel_clr_q, rv_q, rc_q;
   logic [ADDR_W-1:0]   addr_a_q, addr_b_q;
   logic [2:0]          votes_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [QCNT_W-1:0]   qcnt_q;
   logic [PIPE_LAT-1:0] dly_q, dly_d;
   logic [2:0]          vote_cnt;
   logic                vote_maj;

   knn_vote u_vote (
      .cls_i   (cls_in),
      .votes_o (vote_cnt),
      .maj_o   (vote_maj)
   );

   // Strobe tracks mem_en regardless of state so the tail lands in DRAIN.
   always_comb dly_d = (dly_q << 1) | PIPE_LAT'(mem_en_q);

   always_ff @(posedge clk) begin
      if (reset) dly_q <= '0;
      else       dly_q <= dly_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         busy_q    <= 1'b0;
         mem_en_q  <= 1'b0;
         sel_clr_q <= 1'b0;
         rv_q      <= 1'b0;
         rc_q      <= 1'b0;
         votes_q   <= '0;
         addr_a_q  <= '0;
         addr_b_q  <= ADDR_W'(1);
         cnt_q     <= '0;
         qcnt_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q   <= CLEAR;
                  busy_q    <= 1'b1;
                  sel_clr_q <= 1'b1;
               end
            end
            CLEAR: begin
               sel_clr_q <= 1'b0;
               mem_en_q  <= 1'b1;
               addr_a_q  <= '0;
               addr_b_q  <= ADDR_W'(1);
               state_q   <= ISSUE;
            end
            ISSUE: begin
               // Pair index is implicit in addr_a; last pair stops before the
               // step that would overflow ADDR_W.
               if (addr_a_q == LAST_A) begin
                  mem_en_q <= 1'b0;
                  addr_a_q <= '0;
                  addr_b_q <= ADDR_W'(1);
                  cnt_q    <= CNT_W'(PIPE_LAT - 1);
                  state_q  <= DRAIN;
               end else begin
                  addr_a_q <= addr_a_q + ADDR_W'(2);
                  addr_b_q <= addr_b_q + ADDR_W'(2);
               end
            end
            DRAIN: begin
               if (cnt_q == '0) begin
                  cnt_q   <= CNT_W'(SEL_LAT - 1);
                  state_q <= SETTLE;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            SETTLE: begin
               if (cnt_q == '0) begin
                  votes_q <= vote_cnt;
                  rc_q    <= vote_maj;
                  rv_q    <= 1'b1;
                  state_q <= RESULT;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            RESULT: begin
               if (result_ready) begin
                  rv_q    <= 1'b0;
                  busy_q  <= 1'b0;
                  qcnt_q  <= qcnt_q + QCNT_W'(1);
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy         = busy_q;
   assign mem_en       = mem_en_q;
   assign addr_a       = addr_a_q;
   assign addr_b       = addr_b_q;
   assign sel_clr      = sel_clr_q;
   assign sel_valid    = dly_q[PIPE_LAT-1];
   assign result_valid = rv_q;
   assign result_class = rc_q;
   assign result_votes = votes_q;
   assign query_cnt    = qcnt_q;
endmodule

// File: tb/tb_knn_query_ctrl.sv
// Directed bench for knn_query_ctrl with N_TRAIN=8, PIPE_LAT=3, SEL_LAT=1,
// QCNT_W=2; outputs are sampled and inputs driven on the falling edge.
module tb_knn_query_ctrl;
   localparam int N_TRAIN = 8;
   localparam int ADDR_W  = 3;
   localparam int QCNT_W  = 2;

   logic              clk = 1'b0;
   logic              reset, start, result_ready;
   logic [4:0]        cls_in;
   logic              busy, mem_en, sel_clr, sel_valid, result_valid, result_class;
   logic [ADDR_W-1:0] addr_a, addr_b;
   logic [2:0]        result_votes;
   logic [QCNT_W-1:0] query_cnt;

   knn_query_ctrl #(
      .N_TRAIN(N_TRAIN), .ADDR_W(ADDR_W), .PIPE_LAT(3), .SEL_LAT(1), .QCNT_W(QCNT_W)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .mem_en(mem_en),
      .addr_a(addr_a), .addr_b(addr_b), .sel_clr(sel_clr), .sel_valid(sel_valid),
      .cls_in(cls_in), .result_valid(result_valid), .result_ready(result_ready),
      .result_class(result_class), .result_votes(result_votes), .query_cnt(query_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int exp_q = 0;
   int wseq [5];

   logic              clr_l [64], rv_l [64], sv_l [64], me_l [64], busy_l [64], cl_l [64];
   logic [ADDR_W-1:0] aa_l [64], ab_l [64];
   logic [2:0]        vt_l [64];
   logic [QCNT_W-1:0] qc_l [64];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Runs n cycles with result_ready high, logging outputs per cycle c.
   task automatic window(input int n, input int hold_until, input int pulse_at, input int rst_at);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         start  = (c <= hold_until) || (c == pulse_at);
         reset  = (c == rst_at);
         clr_l[c] = sel_clr;  rv_l[c] = result_valid; sv_l[c] = sel_valid;
         me_l[c]  = mem_en;   busy_l[c] = busy;       cl_l[c] = result_class;
         aa_l[c]  = addr_a;   ab_l[c] = addr_b;       vt_l[c] = result_votes;
         qc_l[c]  = query_cnt;
      end
      start = 1'b0;
      reset = 1'b0;
   endtask

   task automatic bp_query(input logic [4:0] cls, input int hold, input int ev, input int ec);
      int t;
      @(negedge clk);
      start = 1'b1; cls_in = cls; result_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      t = 0;
      while (result_valid !== 1'b1 && t < 40) begin
         @(negedge clk);
         t++;
      end
      chk("rv_rise", result_valid, 1);
      chk("latency", t, 9);
      cls_in = ~cls;
      for (int i = 0; i < hold; i++) begin
         chk("bp_rv", result_valid, 1);
         chk("bp_votes", result_votes, ev);
         chk("bp_class", result_class, ec);
         chk("bp_qcnt", query_cnt, exp_q);
         @(negedge clk);
      end
      chk("hs_votes", result_votes, ev);
      chk("hs_class", result_class, ec);
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      exp_q = (exp_q + 1) % 4;
      chk("post_rv", result_valid, 0);
      chk("post_busy", busy, 0);
      chk("post_qcnt", query_cnt, exp_q);
   endtask

   initial begin
      wseq = '{1, 2, 3, 0, 1};
      reset = 1'b1; start = 1'b0; result_ready = 1'b0; cls_in = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);       chk("rst_mem_en", mem_en, 0);
      chk("rst_clr", sel_clr, 0);     chk("rst_selv", sel_valid, 0);
      chk("rst_rv", result_valid, 0); chk("rst_class", result_class, 0);
      chk("rst_votes", result_votes, 0);
      chk("rst_addr_a", addr_a, 0);   chk("rst_addr_b", addr_b, 1);
      chk("rst_qcnt", query_cnt, 0);
      reset = 1'b0;

      // Basic timing, cls 10110 -> 3 votes, class 1
      result_ready = 1'b1; cls_in = 5'b10110;
      window(13, 0, -1, -1);
      for (int c = 0; c < 13; c++) begin
         chk($sformatf("clr@%0d", c), clr_l[c], (c == 1));
         chk($sformatf("mem_en@%0d", c), me_l[c], (c >= 2 && c <= 5));
         chk($sformatf("selv@%0d", c), sv_l[c], (c >= 5 && c <= 8));
         chk($sformatf("rv@%0d", c), rv_l[c], (c == 10));
         chk($sformatf("busy@%0d", c), busy_l[c], (c >= 1 && c <= 10));
         if (c >= 2 && c <= 5) begin
            chk($sformatf("addr_a@%0d", c), aa_l[c], 2 * (c - 2));
            chk($sformatf("addr_b@%0d", c), ab_l[c], 2 * (c - 2) + 1);
         end
      end
      chk("basic_votes", vt_l[10], 3);
      chk("basic_class", cl_l[10], 1);
      chk("basic_qcnt", qc_l[12], 1);
      exp_q = 1;

      bp_query(5'b00011, 4, 2, 0);
      bp_query(5'b11111, 0, 5, 1);

      // Start pulse during ISSUE must be ignored
      result_ready = 1'b1; cls_in = 5'b11011;
      window(16, 0, 3, -1);
      for (int c = 0; c < 16; c++) begin
         chk($sformatf("pulse_clr@%0d", c), clr_l[c], (c == 1));
         chk($sformatf("pulse_rv@%0d", c), rv_l[c], (c == 10));
         chk($sformatf("pulse_busy@%0d", c), busy_l[c], (c >= 1 && c <= 10));
      end
      chk("pulse_votes", vt_l[10], 4);
      exp_q = (exp_q + 1) % 4;
      chk("pulse_qcnt", qc_l[15], exp_q);

      // Start held high: second CLEAR only after returning to IDLE
      window(24, 20, -1, -1);
      for (int c = 0; c < 23; c++) begin
         chk($sformatf("held_clr@%0d", c), clr_l[c], (c == 1 || c == 12));
         chk($sformatf("held_rv@%0d", c), rv_l[c], (c == 10 || c == 21));
      end
      exp_q = (exp_q + 2) % 4;
      chk("held_qcnt", qc_l[23], exp_q);

      // Reset in cycle 3 (mid-ISSUE)
      window(14, 0, -1, 3);
      chk("mrst_busy", busy_l[4], 0);  chk("mrst_mem_en", me_l[4], 0);
      chk("mrst_rv", rv_l[4], 0);      chk("mrst_class", cl_l[4], 0);
      chk("mrst_votes", vt_l[4], 0);
      chk("mrst_addr_a", aa_l[4], 0);  chk("mrst_addr_b", ab_l[4], 1);
      chk("mrst_qcnt", qc_l[4], 0);
      for (int c = 4; c < 14; c++) begin
         chk($sformatf("mrst_selv@%0d", c), sv_l[c], 0);
         chk($sformatf("mrst_clr@%0d", c), clr_l[c], 0);
         chk($sformatf("mrst_busy@%0d", c), busy_l[c], 0);
      end
      exp_q = 0;

      // Counter wrap with QCNT_W=2
      for (int i = 0; i < 5; i++) begin
         bp_query(5'b00111, 0, 3, 1);
         chk($sformatf("wrap%0d", i), query_cnt, wseq[i]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
